counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_if.sv | 30 +++
 rtl/counter_bus_drv.sv | 16 +
 rtl/counter.sv | 54 +++++
 tb/tb_counter.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the program counter.
// Optional feature macro: COUNTER_WRAP_FLAG_EN (adds the registered wrap flag).
package counter_pkg;

    // Default program-counter width in bits.
    localparam int COUNTER_WIDTH = 4;

    // Widest counter the address constants cover; slice them down to WIDTH.
    localparam int COUNTER_MAX_W = 32;

    // All-ones and zero addresses: wrap detection and the reset value.
    localparam logic [COUNTER_MAX_W-1:0] ADDR_ONES = '1;
    localparam logic [COUNTER_MAX_W-1:0] ADDR_ZERO = '0;

endpackage : counter_pkg

// File: rtl/counter_if.sv
// Control bundle for the program counter.
// Optional feature macro: COUNTER_WRAP_FLAG_EN (adds the wrap flag to the bundle).
//
// Control semantics: jmp and inc are level-qualified commands sampled on every
// rising clk edge. There is no ready back-pressure; the counter accepts a
// command on every edge. jmp outranks inc, and in is only sampled on an edge
// where jmp is high. oe only selects whether the count is driven onto the bus.
interface counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
);

    logic [0:WIDTH-1] in;
    logic             oe;
    logic             jmp;
    logic             inc;
`ifdef COUNTER_WRAP_FLAG_EN
    logic             wrap;
`endif

`ifdef COUNTER_WRAP_FLAG_EN
    modport master (output in, output oe, output jmp, output inc, input wrap);
    modport slave  (input in, input oe, input jmp, input inc, output wrap);
`else
    modport master (output in, output oe, output jmp, output inc);
    modport slave  (input in, input oe, input jmp, input inc);
`endif

endinterface : counter_if

// File: rtl/counter_bus_drv.sv
// Tri-state driver that places the count onto the shared bus.
// Optional feature macro: COUNTER_WRAP_FLAG_EN (not used in this file).
module counter_bus_drv
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic [0:WIDTH-1] data,
    input  logic             oe,
    output tri   [0:WIDTH-1] bus
);

    // Purely combinational: the bus follows oe and data with no register stage.
    assign bus = oe ? data : {WIDTH{1'bz}};

endmodule : counter_bus_drv

// File: rtl/counter.sv
// Program counter with jump/increment and a tri-state bus output.
// Optional feature macro: COUNTER_WRAP_FLAG_EN (adds the registered wrap flag).
//
// out stays a plain port rather than living in the interface so the
// tri-state net resolves at the bus level, where other drivers also attach.
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    counter_if.slave         bus,
    output tri   [0:WIDTH-1] out
);

    localparam logic [0:WIDTH-1] STORE_ZERO = ADDR_ZERO[WIDTH-1:0];

    // Count register; the name is referenced hierarchically by benches.
    logic [0:WIDTH-1] store;

    // Count register: clr clears at once; jmp loads in, otherwise inc advances.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            store <= STORE_ZERO;
        end else if (bus.jmp) begin
            store <= bus.in;
        end else if (bus.inc) begin
            store <= store + WIDTH'(1);
        end
    end

`ifdef COUNTER_WRAP_FLAG_EN
    localparam logic [0:WIDTH-1] STORE_ONES = ADDR_ONES[WIDTH-1:0];

    // Wrap flag: one-cycle pulse after an increment rolls all-ones over to zero.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bus.wrap <= 1'b0;
        end else begin
            bus.wrap <= !bus.jmp && bus.inc && (store == STORE_ONES);
        end
    end
`endif

    counter_bus_drv #(
        .WIDTH (WIDTH)
    ) u_bus_drv (
        .data (store),
        .oe   (bus.oe),
        .bus  (out)
    );

endmodule : counter

// File: tb/tb_counter.sv
// Directed self-checking bench for the program counter.
// Optional feature macro: COUNTER_WRAP_FLAG_EN (enables the wrap-flag checks).
module tb_counter;

    import counter_pkg::*;

    localparam int W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    // ---------------- DUT hookup ----------------
    counter_if #(.WIDTH(W)) bus_if ();

    tri   [0:W-1] out;

    // Second bus driver: only enabled while the counter must be off the bus,
    // so the value read back shows whether the counter really released it.
    logic         tb_drv_en;
    logic [0:W-1] tb_drv_val;
    assign out = tb_drv_en ? tb_drv_val : {W{1'bz}};

    counter #(.WIDTH(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if.slave),
        .out (out)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic oe, input logic jmp, input logic inc, input logic [0:W-1] in);
        bus_if.oe  = oe;
        bus_if.jmp = jmp;
        bus_if.inc = inc;
        bus_if.in  = in;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clr        = 1'b1;
        tb_drv_en  = 1'b0;
        tb_drv_val = '0;
        drive(1'b1, 1'b0, 1'b0, 4'h0);

        // Asynchronous clear before any clock edge.
        #3;
        clr = 1'b0;
        #1;
        check_val("reset_out", out, 4'h0);
        check_val("reset_store", dut.store, 4'h0);
`ifdef COUNTER_WRAP_FLAG_EN
        check_val("reset_wrap", bus_if.wrap, 1'b0);
`endif

        // clr overrides inc across an edge.
        drive(1'b1, 1'b0, 1'b1, 4'h0);
        step();
        check_val("clr_over_inc", dut.store, 4'h0);
        clr = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 4'h0);

        // Four increments: 1,2,3,4.
        drive(1'b1, 1'b0, 1'b1, 4'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_val($sformatf("inc_%0d", i), out, 32'(i));
        end

        // Idle holds; in changes without jmp are ignored.
        drive(1'b1, 1'b0, 1'b0, 4'h9);
        step();
        check_val("hold_ignore_in", out, 4'h4);

        // jmp beats inc, then a plain increment from the jump target.
        drive(1'b1, 1'b1, 1'b1, 4'hA);
        step();
        check_val("jmp_priority", out, 4'hA);
        drive(1'b1, 1'b0, 1'b1, 4'h3);
        step();
        check_val("inc_after_jmp", out, 4'hB);

        // Wrap from all-ones.
        drive(1'b1, 1'b1, 1'b0, 4'hF);
        step();
        check_val("jmp_to_f", out, 4'hF);
`ifdef COUNTER_WRAP_FLAG_EN
        check_val("wrap_not_on_jmp", bus_if.wrap, 1'b0);
`endif
        drive(1'b1, 1'b0, 1'b1, 4'h0);
        step();
        check_val("wrap_out", out, 4'h0);
`ifdef COUNTER_WRAP_FLAG_EN
        check_val("wrap_pulse", bus_if.wrap, 1'b1);
`endif
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        step();
        check_val("wrap_hold", out, 4'h0);
`ifdef COUNTER_WRAP_FLAG_EN
        check_val("wrap_one_cycle", bus_if.wrap, 1'b0);
        // Jumping away from all-ones must not flag a wrap.
        drive(1'b1, 1'b1, 1'b0, 4'hF);
        step();
        drive(1'b1, 1'b1, 1'b1, 4'h0);
        step();
        check_val("wrap_jmp_from_f", bus_if.wrap, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'h0);
`endif

        // oe low: counter releases the bus, counting continues underneath.
        bus_if.oe  = 1'b0;
        tb_drv_val = 4'h5;
        tb_drv_en  = 1'b1;
        #1;
        check_val("oe_low_release", out, 4'h5);
        drive(1'b0, 1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 3; i++) step();
        check_val("oe_low_count", dut.store, 4'h3);
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        tb_drv_en  = 1'b0;
        bus_if.oe  = 1'b1;
        #1;
        check_val("oe_raise", out, 4'h3);

        // Mid-count clear between edges.
        drive(1'b1, 1'b1, 1'b0, 4'h6);
        step();
        check_val("jmp_to_6", out, 4'h6);
        drive(1'b1, 1'b0, 1'b1, 4'h0);
        #2;
        clr = 1'b0;
        #1;
        check_val("midclr_store", dut.store, 4'h0);
        check_val("midclr_out", out, 4'h0);
        step();
        check_val("clr_hold_1", dut.store, 4'h0);
        step();
        check_val("clr_hold_2", out, 4'h0);
        clr = 1'b1;
        #1;
        check_val("clr_release_no_edge", out, 4'h0);
        step();
        check_val("first_op_after_clr", out, 4'h1);
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        step();
        check_val("final_hold", out, 4'h1);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_counter
